// File: rtl/lane_stripe_ctrl.sv
// lane_stripe_ctrl: stripes a byte stream into lane0/lane1 pairs, padding odd bytes on packet end or idle timeout
module lane_stripe_ctrl #(
    parameter logic [7:0] PAD = 8'hF7,
    parameter int TIMEOUT = 4,
    parameter int CNTW = 16
) (
    input  logic            clkf,
    input  logic            reset,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [7:0]      out0,
    output logic [7:0]      out1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_pad1,
    output logic            busy,
    output logic [CNTW-1:0] pair_cnt
);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    typedef enum logic {EMPTY, HALF} state_t;
    state_t state, state_n;
    logic [7:0] hold0;
    logic [TW-1:0] tmr;
    logic acc, tout, emit;
    assign in_ready = !out_valid | out_ready;
    assign busy = (state == HALF) | out_valid;
    always_comb begin
        acc = in_valid & in_ready;
        tout = (TIMEOUT != 0) & (state == HALF) & !acc & (tmr == TMAX) & in_ready;
        emit = (acc & ((state == HALF) | in_last)) | tout;
        state_n = state == EMPTY ? (acc & !in_last ? HALF : EMPTY) : (acc | tout ? EMPTY : HALF);
    end
    always_ff @(posedge clkf) begin
        if (!reset) begin
            state <= EMPTY;
            hold0 <= '0;
            tmr <= '0;
            out0 <= '0;
            out1 <= '0;
            out_pad1 <= 1'b0;
            out_valid <= 1'b0;
            pair_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == EMPTY && acc && !in_last)
                hold0 <= in_data;
            // timer keeps running through output stalls so the flush fires on the first free slot
            tmr <= (acc || state == EMPTY) ? '0 : (tmr == TMAX ? tmr : tmr + 1'b1);
            if (emit) begin
                out0 <= state == HALF ? hold0 : in_data;
                out1 <= (state == HALF && acc) ? in_data : PAD;
                out_pad1 <= !(state == HALF && acc);
                pair_cnt <= pair_cnt + 1'b1;
            end
            out_valid <= emit | (out_valid & !out_ready);
        end
    end
endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// tb_lane_stripe_ctrl: directed stimulus with a queue scoreboard for lane_stripe_ctrl
module tb_lane_stripe_ctrl;
    localparam logic [7:0] PAD = 8'hF7;
    localparam int TMO = 4;
    logic clkf = 1'b0;
    logic reset = 1'b0;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic in_ready;
    logic [7:0] out0, out1;
    logic out_valid;
    logic out_ready = 1'b0;
    logic out_pad1;
    logic busy;
    logic [15:0] pair_cnt;
    int checks = 0;
    int errors = 0;
    logic [16:0] q[$];
    bit m_ov, m_half, last_acc;
    logic [7:0] m_hold;
    int m_tmr;
    logic [15:0] m_cnt;

    lane_stripe_ctrl dut (
        .clkf(clkf), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out0(out0), .out1(out1), .out_valid(out_valid), .out_ready(out_ready),
        .out_pad1(out_pad1), .busy(busy), .pair_cnt(pair_cnt)
    );

    always #5 clkf = ~clkf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ov = 0; m_half = 0; m_hold = '0; m_tmr = 0; m_cnt = '0; last_acc = 0;
    endtask

    // one clock: compare at negedge against the model, advance model, step past posedge
    task automatic tick();
        bit rdy, acc, fire, emit;
        @(negedge clkf);
        last_acc = 0;
        if (reset) begin
            rdy = !m_ov || out_ready;
            acc = in_valid && rdy;
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("pair_cnt", 32'(pair_cnt), 32'(m_cnt));
            if (m_ov) begin
                if (q.size() == 0) chk("scoreboard_empty", 1, 0);
                else chk("pair", 32'({out0, out1, out_pad1}), 32'(q[0]));
            end
            fire = m_ov && out_ready;
            if (fire && q.size() != 0) void'(q.pop_front());
            emit = 0;
            if (m_half && acc) begin
                q.push_back({m_hold, in_data, 1'b0}); m_half = 0; emit = 1;
            end else if (!m_half && acc && in_last) begin
                q.push_back({in_data, PAD, 1'b1}); emit = 1;
            end else if (!m_half && acc) begin
                m_hold = in_data; m_half = 1; m_tmr = 0;
            end else if (m_half && m_tmr == TMO && rdy) begin
                q.push_back({m_hold, PAD, 1'b1}); m_half = 0; emit = 1;
            end else if (m_half && m_tmr < TMO) begin
                m_tmr++;
            end
            if (emit) m_cnt++;
            m_ov = emit ? 1'b1 : (fire ? 1'b0 : m_ov);
            last_acc = acc;
        end
        @(posedge clkf);
        if (!reset) model_clear();
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit l);
        bit got;
        got = 0;
        in_valid = 1; in_data = d; in_last = l;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            got = last_acc;
        end
        if (!got) chk("accept_timeout", 0, 1);
        in_valid = 0; in_last = 0;
    endtask

    initial begin
        model_clear();
        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); in_last = 1'($urandom); in_data = 8'($urandom); out_ready = 1'($urandom);
            tick();
        end
        chk("rst_out0", 32'(out0), 0);
        chk("rst_out1", 32'(out1), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_pair_cnt", 32'(pair_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        in_valid = 0; in_last = 0; out_ready = 1; reset = 1;
        tick();
        // 2: back-to-back stream
        in_valid = 1;
        in_data = 8'h11; tick();
        chk("half_busy", 32'(busy), 1);
        in_data = 8'h22; tick();
        chk("p1_valid", 32'(out_valid), 1);
        chk("p1", 32'({out0, out1, out_pad1}), 32'({8'h11, 8'h22, 1'b0}));
        in_data = 8'h33; tick();
        in_data = 8'h44; tick();
        in_valid = 0;
        chk("p2", 32'({out0, out1, out_pad1}), 32'({8'h33, 8'h44, 1'b0}));
        chk("cnt2", 32'(pair_cnt), 2);
        tick();
        // 3: single-byte packet
        send(8'hA5, 1);
        chk("last_pad", 32'({out_valid, out0, out1, out_pad1}), 32'({1'b1, 8'hA5, PAD, 1'b1}));
        tick();
        // 4: idle timeout flush, then accept-wins-over-timeout
        send(8'h5A, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("to_not_yet", 32'(out_valid), 0);
        tick();
        chk("to_flush", 32'({out_valid, out0, out1, out_pad1}), 32'({1'b1, 8'h5A, PAD, 1'b1}));
        tick();
        send(8'h5B, 0);
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1; in_data = 8'h3C; tick(); in_valid = 0;
        chk("to_accept_wins", 32'({out_valid, out0, out1, out_pad1}), 32'({1'b1, 8'h5B, 8'h3C, 1'b0}));
        tick(); tick();
        // 5: output stall
        out_ready = 0;
        send(8'h61, 0);
        send(8'h62, 0);
        in_valid = 1; in_data = 8'h63;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_hold", 32'({out0, out1}), 32'({8'h61, 8'h62}));
        end
        out_ready = 1;
        send(8'h63, 0);
        send(8'h64, 0);
        chk("resume", 32'({out0, out1, out_pad1}), 32'({8'h63, 8'h64, 1'b0}));
        tick();
        // 6: reset in HALF drops the held byte; counter wrap
        send(8'h99, 0);
        reset = 0; tick(); reset = 1;
        chk("rst_mid_busy", 32'(busy), 0);
        send(8'h01, 0);
        send(8'h02, 0);
        chk("post_rst_pair", 32'({out0, out1, out_pad1}), 32'({8'h01, 8'h02, 1'b0}));
        in_valid = 1; in_last = 1;
        for (int i = 0; i < 65534; i++) begin
            in_data = 8'(i);
            tick();
        end
        chk("cnt_all_ones", 32'(pair_cnt), 32'h0000FFFF);
        in_data = 8'hEE; tick();
        chk("cnt_wrap", 32'(pair_cnt), 0);
        in_valid = 0; in_last = 0;
        tick(); tick();
        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
